bt_pipe_out_endpoint: RTL and testbench
=======================================

Name: bt_pipe_out_endpoint

Overview:
- Device-side responder for the FrontPanel block-throttled pipe-out transfer (host read direction); sits on the ok1/ok2 endpoint bus beside the wire and trigger endpoints.
- User logic pushes 16-bit words into an internal FIFO on ti_clk.
- The block raises READY on ok2 when a full block is buffered, accepts the host block strobe, and returns one word per host read cycle.
- Drives ok2 to all-zero whenever it is not addressed, so it can be OR-combined with other endpoints.

Parameters:
- EP_ADDR, 8'hA0, endpoint address matched against the ok1 address field (pipe-out range 8'hA0-8'hBF).
- DEPTH_LOG2, 8, FIFO depth is 2^DEPTH_LOG2 words (default 256).
- BLOCK_SIZE, 64, words per block; must satisfy 1 <= BLOCK_SIZE <= 2^DEPTH_LOG2.

Ports:
- ti_clk  in  1  endpoint bus clock; all logic uses its rising edge.
- resetn  in  1  synchronous, active-low reset.
- ok1  in  31  host-to-endpoint bus: [15:0] datain, [23:16] addr, [24] clk, [25] reset, [26] read, [27] write, [28] wireupdate, [29] trigupdate, [30] blockstrobe.
- ok2  out  17  endpoint-to-host bus: [15:0] dataout, [16] ready.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  16  word to buffer.
- full  out  1  FIFO holds 2^DEPTH_LOG2 words.
- empty  out  1  FIFO holds 0 words.
- count  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a host read occurred while empty.
- block_active  out  1  high from accepted block strobe until the last word of the block is read.

Behaviour:
- Address match: sel = (ok1[23:16] == EP_ADDR).
- Reset: clear is (resetn==0) OR ok1[25].
  - Clear empties the FIFO, sets count=0, clears overflow, underflow and block_active, zeroes the data register, sets state IDLE.
  - Outputs during and after reset: ok2=0, empty=1, full=0.
  - A reset in the middle of a block abandons the block; no partial words survive.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth.
  - count is updated as +1 on push only, -1 on pop only, unchanged when both occur in the same cycle.
  - Push while full: the word is dropped, overflow is set, the pointer does not move.
  - Push and pop in the same cycle while full: both are performed.
- States:
  - IDLE: ready=0. Go to ARMED when count >= BLOCK_SIZE.
  - ARMED: ready=1 while sel, else 0. On blockstrobe (ok1[30]) with sel, go to XFER and load words_left=BLOCK_SIZE.
  - XFER: ready=0, block_active=1.
    - Each rising edge with read (ok1[26]) and sel pops one FIFO word into the data register and decrements words_left.
    - When words_left reaches 0, go to IDLE; this rechecks count, so back-to-back blocks re-arm one cycle later.
- Read latency:
  - A read sampled at rising edge N loads the data register at edge N.
  - ok2[15:0] shows the register from edge N until edge N+1, so the host samples it at the following falling edge.
- ok2[15:0] gating:
  - Equals the data register when sel was true at the previous edge, else 0.
  - ok2[16] (ready) is also gated by sel.
- Reads outside XFER:
  - A read with sel in IDLE or ARMED still pops when the FIFO is non-empty (plain pipe-out compatibility).
  - No state change occurs.
- Read while empty (any state): the data register is loaded with 16'h0000, underflow is set, and the pointers and count do not change.
  - In XFER, words_left still decrements so the host transfer completes.
- A blockstrobe outside ARMED, or without sel, is ignored.
- The write (ok1[27]), wireupdate and trigupdate bits are ignored.

Test Plan:
- Reset: push 5 words, then assert resetn=0 for 1 cycle → count=0, empty=1, ok2=17'h0, overflow=0.
- Arm threshold: BLOCK_SIZE=64; push 63 words → ready=0; push the 64th → ready=1 one cycle later, with addr=8'hA0 on ok1.
- Block transfer:
  - Push the values 0..63, blockstrobe at 8'hA0, then 64 reads.
  - Host samples 0,1,...,63 in order; block_active falls after the 64th read; count=0; ready=0.
- Back-to-back blocks: push 128 words, complete one block → ready re-asserts within 2 cycles; the second block returns words 64..127.
- Boundaries:
  - Fill 256 words, push 1 more → overflow=1, count=256.
  - Set the host pipe length to 65 reads on a 64-word FIFO: the 65th returns 16'h0000 and underflow=1.
  - Pointer wrap: 3 fill/drain rounds of 200 words each → data remains in order.
- Bus isolation and reset mid-block:
  - With ok1 addr=8'hA1, a read leaves the FIFO unchanged and ok2=0.
  - ok1[25] pulsed mid-block → block_active=0, count=0, state IDLE.

Source files
------------

// File: rtl/bt_pipe_out_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : bt_pipe_out_endpoint
// Description : Block-throttled pipe-out responder on the ok1/ok2 endpoint
//               bus. It buffers user words and serves them in host blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_pipe_out_endpoint #(
    parameter logic [7:0] EP_ADDR    = 8'hA0,
    parameter int         DEPTH_LOG2 = 8,
    parameter int         BLOCK_SIZE = 64
) (
    input  logic                  ti_clk,
    input  logic                  resetn,
    input  logic [30:0]           ok1,
    output logic [16:0]           ok2,
    input  logic                  wr_en,
    input  logic [15:0]           wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  block_active
);

    localparam int                    c_depth       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_depth_cnt   = (DEPTH_LOG2 + 1)'(c_depth);
    localparam logic [DEPTH_LOG2:0]   c_block_words = (DEPTH_LOG2 + 1)'(BLOCK_SIZE);
    localparam logic [DEPTH_LOG2:0]   c_cnt_one     = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one     = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    // Bus decode
    logic w_clear;
    logic w_sel;
    logic w_rd;
    logic w_strobe;

    // FIFO control
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    logic [15:0]           r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [15:0]           r_data;
    logic                  r_sel_q;
    logic                  r_overflow;
    logic                  r_underflow;

    // Block state machine
    state_t                r_state;
    logic [DEPTH_LOG2:0]   r_words_left;
    logic                  r_armed;
    logic                  r_block_active;

    // Host data, write strobe and update bits carry no meaning for a pipe-out.
    logic w_unused_ok1;
    assign w_unused_ok1 = ^{ok1[29:27], ok1[24], ok1[15:0]};

    assign w_clear  = ~resetn | ok1[25];
    assign w_sel    = (ok1[23:16] == EP_ADDR);
    assign w_rd     = ok1[26] & w_sel;
    assign w_strobe = ok1[30] & w_sel;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_depth_cnt);
    assign w_pop    = w_rd & ~w_empty;
    // A full FIFO still accepts a word when the same cycle frees a slot.
    assign w_push   = wr_en & (~w_full | w_pop);

    always_ff @(posedge ti_clk) begin
        if (w_push && !w_clear) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge ti_clk) begin
        if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_sel_q     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sel_q <= w_sel;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end

            if (wr_en && !w_push) begin
                r_overflow <= 1'b1;
            end

            // An empty read returns zero so the host transfer still completes.
            if (w_rd) begin
                if (w_empty) begin
                    r_data      <= '0;
                    r_underflow <= 1'b1;
                end else begin
                    r_data <= r_mem[r_rd_ptr];
                end
            end
        end
    end

    always_ff @(posedge ti_clk) begin
        if (w_clear) begin
            r_state        <= S_IDLE;
            r_words_left   <= '0;
            r_armed        <= 1'b0;
            r_block_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count >= c_block_words) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_strobe) begin
                        r_state        <= S_XFER;
                        r_armed        <= 1'b0;
                        r_block_active <= 1'b1;
                        r_words_left   <= c_block_words;
                    end
                end
                S_XFER: begin
                    if (w_rd) begin
                        r_words_left <= r_words_left - c_cnt_one;
                        if (r_words_left == c_cnt_one) begin
                            r_state        <= S_IDLE;
                            r_block_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_armed        <= 1'b0;
                    r_block_active <= 1'b0;
                end
            endcase
        end
    end

    // ok2 stays all-zero unless addressed, so endpoints can be OR-combined.
    assign ok2 = w_clear ? 17'h0 :
                 {w_sel & r_armed, (r_sel_q ? r_data : 16'h0000)};

    assign full         = w_full & ~w_clear;
    assign empty        = w_empty | w_clear;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign block_active = r_block_active;

endmodule
`default_nettype wire

// File: tb/tb_bt_pipe_out_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_pipe_out_endpoint
// Description : Directed self-checking bench for bt_pipe_out_endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_pipe_out_endpoint;

    localparam logic [7:0] c_addr  = 8'hA0;
    localparam logic [7:0] c_other = 8'hA1;

    logic        ti_clk;
    logic        resetn;
    logic [30:0] ok1;
    logic [16:0] ok2;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        empty;
    logic [8:0]  count;
    logic        overflow;
    logic        underflow;
    logic        block_active;

    int n_checks = 0;
    int n_errors = 0;

    bt_pipe_out_endpoint #(
        .EP_ADDR    (8'hA0),
        .DEPTH_LOG2 (8),
        .BLOCK_SIZE (64)
    ) u_dut (
        .ti_clk       (ti_clk),
        .resetn       (resetn),
        .ok1          (ok1),
        .ok2          (ok2),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .block_active (block_active)
    );

    initial ti_clk = 1'b0;
    always #5 ti_clk = ~ti_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [30:0] mk_ok1(input logic [7:0] addr, input logic rd,
                                           input logic strobe, input logic host_rst);
        logic [30:0] v;
        v        = '0;
        v[23:16] = addr;
        v[25]    = host_rst;
        v[26]    = rd;
        v[30]    = strobe;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'(base + i);
            @(negedge ti_clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] addr, output logic [15:0] word);
        ok1 = mk_ok1(addr, 1'b1, 1'b0, 1'b0);
        @(negedge ti_clk);
        word = ok2[15:0];
        ok1  = mk_ok1(addr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_block(input string tag, input int base, input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            host_read(c_addr, w);
            chk(tag, 32'(w), 32'(16'(base + i)));
        end
    endtask

    task automatic strobe_block();
        ok1 = mk_ok1(c_addr, 1'b0, 1'b1, 1'b0);
        @(negedge ti_clk);
        ok1 = mk_ok1(c_addr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        ok1 = mk_ok1(c_addr, 1'b0, 1'b0, 1'b0);
        #1;
        while (!ok2[16] && cyc < 8) begin
            @(negedge ti_clk);
            cyc++;
        end
        chk(tag, 32'(ok2[16]), 32'd1);
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        @(negedge ti_clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [15:0] w;
        int          cyc;

        resetn  = 1'b0;
        ok1     = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        @(negedge ti_clk);
        @(negedge ti_clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ok2", 32'(ok2), 32'd0);
        resetn = 1'b1;

        // Reset discards buffered words
        push_words(100, 5);
        chk("pre_rst_count", 32'(count), 32'd5);
        ok1 = mk_ok1(c_addr, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        chk("rst5_count", 32'(count), 32'd0);
        chk("rst5_empty", 32'(empty), 32'd1);
        chk("rst5_ok2", 32'(ok2), 32'd0);
        chk("rst5_overflow", 32'(overflow), 32'd0);

        // Arm threshold
        push_words(0, 63);
        ok1 = mk_ok1(c_addr, 1'b0, 1'b0, 1'b0);
        @(negedge ti_clk);
        chk("arm63_ready", 32'(ok2[16]), 32'd0);
        chk("arm63_count", 32'(count), 32'd63);
        push_words(63, 1);
        chk("arm64_ready_same", 32'(ok2[16]), 32'd0);
        @(negedge ti_clk);
        chk("arm64_ready_next", 32'(ok2[16]), 32'd1);
        ok1 = mk_ok1(c_other, 1'b0, 1'b0, 1'b0);
        #1;
        chk("arm_unselected_ok2", 32'(ok2), 32'd0);
        ok1 = mk_ok1(c_addr, 1'b0, 1'b0, 1'b0);

        // Single block transfer
        strobe_block();
        chk("xfer_active", 32'(block_active), 32'd1);
        chk("xfer_ready", 32'(ok2[16]), 32'd0);
        read_block("blk_data", 0, 63);
        chk("blk_active_63", 32'(block_active), 32'd1);
        read_block("blk_last", 63, 1);
        chk("blk_active_end", 32'(block_active), 32'd0);
        chk("blk_count_end", 32'(count), 32'd0);
        @(negedge ti_clk);
        chk("blk_ready_end", 32'(ok2[16]), 32'd0);

        // Back-to-back blocks
        push_words(0, 128);
        wait_ready("b2b_ready1");
        strobe_block();
        read_block("b2b_blk1", 0, 64);
        cyc = 0;
        ok1 = mk_ok1(c_addr, 1'b0, 1'b0, 1'b0);
        #1;
        while (!ok2[16] && cyc < 8) begin
            @(negedge ti_clk);
            cyc++;
        end
        chk("b2b_rearm_cycles", 32'(cyc), 32'd1);
        strobe_block();
        read_block("b2b_blk2", 64, 64);
        chk("b2b_count_end", 32'(count), 32'd0);

        // Full, simultaneous push/pop, overflow
        push_words(1000, 256);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd256);
        wr_en   = 1'b1;
        wr_data = 16'd2000;
        ok1     = mk_ok1(c_addr, 1'b1, 1'b0, 1'b0);
        @(negedge ti_clk);
        w     = ok2[15:0];
        wr_en = 1'b0;
        ok1   = mk_ok1(c_addr, 1'b0, 1'b0, 1'b0);
        chk("pushpop_word", 32'(w), 32'd1000);
        chk("pushpop_count", 32'(count), 32'd256);
        chk("pushpop_overflow", 32'(overflow), 32'd0);
        push_words(2001, 1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd256);
        read_block("drain_data", 1001, 255);
        read_block("drain_last", 2000, 1);
        chk("drain_empty", 32'(empty), 32'd1);
        pulse_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Host reads one word beyond the block
        push_words(3000, 64);
        wait_ready("unf_ready");
        strobe_block();
        read_block("unf_data", 3000, 64);
        chk("unf_before", 32'(underflow), 32'd0);
        host_read(c_addr, w);
        chk("unf_word", 32'(w), 32'd0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_count", 32'(count), 32'd0);

        // Pointer wrap across several fill/drain rounds
        for (int r = 0; r < 3; r++) begin
            push_words(5000 + r * 200, 200);
            read_block("wrap_data", 5000 + r * 200, 200);
        end
        chk("wrap_count", 32'(count), 32'd0);

        // Bus isolation
        pulse_reset();
        chk("iso_unf_cleared", 32'(underflow), 32'd0);
        push_words(7000, 10);
        host_read(c_other, w);
        chk("iso_ok2", 32'(ok2), 32'd0);
        chk("iso_count", 32'(count), 32'd10);
        host_read(c_addr, w);
        chk("iso_word", 32'(w), 32'd7000);
        chk("iso_count_after", 32'(count), 32'd9);

        // Host reset in the middle of a block
        pulse_reset();
        push_words(8000, 64);
        wait_ready("mid_ready");
        strobe_block();
        read_block("mid_data", 8000, 10);
        ok1 = mk_ok1(c_addr, 1'b0, 1'b0, 1'b1);
        @(negedge ti_clk);
        chk("mid_active", 32'(block_active), 32'd0);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_ok2", 32'(ok2), 32'd0);
        ok1 = mk_ok1(c_addr, 1'b0, 1'b0, 1'b0);
        @(negedge ti_clk);
        chk("mid_ready_idle", 32'(ok2[16]), 32'd0);
        push_words(9000, 64);
        wait_ready("post_ready");
        strobe_block();
        read_block("post_data", 9000, 64);
        chk("post_active", 32'(block_active), 32'd0);
        chk("post_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
